// File: rtl/otp_chunk_xor_if.sv
// Chunk stream between the message shifter and the pad XOR stage, plus the
// start/pad control and the status/ciphertext returned by the XOR stage.
interface otp_chunk_xor_if #(
    parameter int KEY_SIZE = 16,
    parameter int MSG_SIZE = 240
);
    localparam int CNT_W = $clog2(MSG_SIZE / KEY_SIZE + 1);

    logic                start;
    logic [MSG_SIZE-1:0] pad;
    logic                in_valid;
    logic [KEY_SIZE-1:0] in_chunk;
    logic                in_ready;
    logic                out_valid;
    logic [KEY_SIZE-1:0] out_chunk;
    logic [MSG_SIZE-1:0] cipher;
    logic [CNT_W-1:0]    chunk_cnt;
    logic                busy;
    logic                done;

    modport master (
        output start, pad, in_valid, in_chunk,
        input  in_ready, out_valid, out_chunk, cipher, chunk_cnt, busy, done
    );

    modport slave (
        input  start, pad, in_valid, in_chunk,
        output in_ready, out_valid, out_chunk, cipher, chunk_cnt, busy, done
    );
endinterface

// File: rtl/otp_chunk_xor.sv
// XORs MSB-first message chunks with the matching slice of a latched pad,
// streaming each ciphertext chunk and reassembling the full ciphertext.
module otp_chunk_xor #(
    parameter int KEY_SIZE = 16,
    parameter int MSG_SIZE = 240   // must be a multiple of KEY_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    otp_chunk_xor_if.slave  bus
);
    localparam int CHUNKS = MSG_SIZE / KEY_SIZE;
    localparam int CNT_W  = $clog2(CHUNKS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q;
    logic [MSG_SIZE-1:0] pad_q;
    logic [MSG_SIZE-1:0] cipher_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [KEY_SIZE-1:0] out_chunk_q;
    logic                out_valid_q;
    logic [KEY_SIZE-1:0] xor_d;

    // The pad register shifts left on every accept, so the key for the
    // current chunk is always its top slice; no index arithmetic needed.
    assign xor_d = bus.in_chunk ^ pad_q[MSG_SIZE-1 -: KEY_SIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pad_q       <= '0;
            cipher_q    <= '0;
            cnt_q       <= '0;
            out_chunk_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        pad_q    <= bus.pad;
                        cipher_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (bus.in_valid) begin
                        out_chunk_q <= xor_d;
                        out_valid_q <= 1'b1;
                        cipher_q    <= (cipher_q << KEY_SIZE) | MSG_SIZE'(xor_d);
                        pad_q       <= pad_q << KEY_SIZE;
                        cnt_q       <= cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX)
                            state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == RUN);
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_chunk = out_chunk_q;
    assign bus.cipher    = cipher_q;
    assign bus.chunk_cnt = cnt_q;
endmodule

// File: tb/tb_otp_chunk_xor.sv
// Directed bench for otp_chunk_xor at default sizes (16-bit chunks, 240-bit message).
module tb_otp_chunk_xor;
    localparam int K = 16;
    localparam int M = 240;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [M-1:0] msg     = 240'hABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF012345;
    logic [M-1:0] not_msg = 240'h543210FEDCBA9876543210FEDCBA9876543210FEDCBA9876543210FEDCBA;
    logic [M-1:0] pad2    = {15{16'h00FF}};
    logic [M-1:0] pad2_ct = 240'hAB32EFFE23BA6776AB32EFFE23BA6776AB32EFFE23BA6776AB32EFFE23BA;
    logic [K-1:0] first_out, second_out;

    otp_chunk_xor_if #(.KEY_SIZE(K), .MSG_SIZE(M)) bus ();

    otp_chunk_xor #(.KEY_SIZE(K), .MSG_SIZE(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"},  M'(bus.in_ready),  '0);
        chk({tag, "_out_valid"}, M'(bus.out_valid), '0);
        chk({tag, "_out_chunk"}, M'(bus.out_chunk), '0);
        chk({tag, "_cipher"},    bus.cipher,        '0);
        chk({tag, "_cnt"},       M'(bus.chunk_cnt), '0);
        chk({tag, "_busy"},      M'(bus.busy),      '0);
        chk({tag, "_done"},      M'(bus.done),      '0);
    endtask

    // Start a message with pad p and feed all chunks of msg. gap inserts an
    // idle cycle after every accept; mid_start pulses start (with a different
    // pad) together with that chunk index, which must be ignored.
    task automatic run_msg(input string tag, input logic [M-1:0] p, input logic [M-1:0] exp_ct,
                           input bit gap, input int mid_start);
        logic [K-1:0] exp_c;
        bus.start = 1'b1;
        bus.pad   = p;
        tick();
        bus.start = 1'b0;
        bus.pad   = '0;
        chk({tag, "_start_busy"},  M'(bus.busy),      M'(1));
        chk({tag, "_start_ready"}, M'(bus.in_ready),  M'(1));
        chk({tag, "_start_done"},  M'(bus.done),      '0);
        chk({tag, "_start_cnt"},   M'(bus.chunk_cnt), '0);
        chk({tag, "_start_ct"},    bus.cipher,        '0);
        for (int i = 0; i < 15; i++) begin
            if (i == mid_start) begin
                bus.start = 1'b1;
                bus.pad   = ~p;
            end
            bus.in_valid = 1'b1;
            bus.in_chunk = msg[M-1-K*i -: K];
            tick();
            bus.start    = 1'b0;
            bus.pad      = '0;
            bus.in_valid = 1'b0;
            exp_c = msg[M-1-K*i -: K] ^ p[M-1-K*i -: K];
            if (i == 0) first_out = bus.out_chunk;
            if (i == 1) second_out = bus.out_chunk;
            chk({tag, "_ovld"},  M'(bus.out_valid), M'(1));
            chk({tag, "_ochunk"}, M'(bus.out_chunk), M'(exp_c));
            chk({tag, "_cnt"},   M'(bus.chunk_cnt), M'(i + 1));
            if (i < 14) chk({tag, "_not_done"}, M'(bus.done), '0);
            if (gap) begin
                tick();
                chk({tag, "_gap_ovld"}, M'(bus.out_valid), '0);
                chk({tag, "_gap_cnt"},  M'(bus.chunk_cnt), M'(i + 1));
            end
        end
        if (!gap) begin
            chk({tag, "_done"},  M'(bus.done),     M'(1));
            chk({tag, "_busy"},  M'(bus.busy),     '0);
            chk({tag, "_ready"}, M'(bus.in_ready), '0);
        end
        chk({tag, "_cipher"}, bus.cipher, exp_ct);
        bus.in_valid = 1'b1;   // ignored in DONE
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_hold_done"},   M'(bus.done),      M'(1));
        chk({tag, "_hold_ovld"},   M'(bus.out_valid), '0);
        chk({tag, "_hold_cnt"},    M'(bus.chunk_cnt), M'(15));
        chk({tag, "_hold_cipher"}, bus.cipher,        exp_ct);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.pad      = '0;
        bus.in_valid = 1'b0;
        bus.in_chunk = '0;
        first_out    = '0;
        second_out   = '0;

        tick();
        tick();
        chk_reset_state("reset");
        rst = 1'b0;

        // in_valid in IDLE must be ignored
        bus.in_valid = 1'b1;
        bus.in_chunk = 16'hABCD;
        tick();
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk_reset_state("idle_valid");

        run_msg("zero_pad", '0, msg, 1'b0, -1);
        chk("zero_first", M'(first_out),  M'(16'hABCD));
        chk("zero_second", M'(second_out), M'(16'hEF01));

        run_msg("self_pad", msg, '0, 1'b0, -1);

        run_msg("ones_gap", '1, not_msg, 1'b1, -1);
        chk("ones_first", M'(first_out),  M'(16'h5432));
        chk("ones_second", M'(second_out), M'(16'h10FE));

        run_msg("mid_start", '0, msg, 1'b0, 5);

        // start from DONE with a new pad
        run_msg("done_restart", pad2, pad2_ct, 1'b0, -1);

        // reset after 7 accepts discards the partial message
        bus.start = 1'b1;
        bus.pad   = '1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_chunk = msg[M-1-K*i -: K];
            tick();
        end
        bus.in_valid = 1'b0;
        chk("partial_cnt", M'(bus.chunk_cnt), M'(7));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("mid_rst");
        run_msg("after_rst", '0, msg, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
